// File: rtl/prbs_pkg.sv
// Shared constants and state encoding for the XNOR-PRBS checker and its matching generator.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int unsigned PRBS7_WIDTH  = 7;
  localparam int unsigned PRBS7_TAP_A  = 7;
  localparam int unsigned PRBS7_TAP_B  = 6;

  localparam int unsigned PRBS15_WIDTH = 15;
  localparam int unsigned PRBS15_TAP_A = 15;
  localparam int unsigned PRBS15_TAP_B = 14;

  localparam int unsigned BITCNT_W     = 32;

endpackage

// File: rtl/prbs_xnor_lfsr.sv
// XNOR-feedback LFSR core: left shift with selectable insert bit (external data or own prediction).
module prbs_xnor_lfsr
  import prbs_pkg::*;
#(
  parameter int unsigned WIDTH = PRBS7_WIDTH,
  parameter int unsigned TAP_A = PRBS7_TAP_A,
  parameter int unsigned TAP_B = PRBS7_TAP_B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_shift_en,
  input  logic             i_sel_pred,
  input  logic             i_din,
  output logic             o_pred,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_sreg;
  logic             w_ins;

  assign o_pred = ~(r_sreg[TAP_A-1] ^ r_sreg[TAP_B-1]);
  assign w_ins  = i_sel_pred ? o_pred : i_din;
  assign o_next = {r_sreg[WIDTH-2:0], w_ins};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg <= '0;
    end else if (i_shift_en) begin
      r_sreg <= o_next;
    end
  end

endmodule

// File: rtl/prbs_xnor_checker.sv
// Self-seeding XNOR-PRBS receive checker with lock detection and saturating error count.
// Optional PRBS_CHK_BITCNT_EN adds bit_cnt, the number of valid bits checked while locked.
module prbs_xnor_checker
  import prbs_pkg::*;
#(
  parameter int unsigned WIDTH       = PRBS7_WIDTH,
  parameter int unsigned TAP_A       = PRBS7_TAP_A,
  parameter int unsigned TAP_B       = PRBS7_TAP_B,
  parameter int unsigned LOCK_CNT    = 8,
  parameter int unsigned UNLOCK_ERRS = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [BITCNT_W-1:0] bit_cnt
`endif
);

  localparam int unsigned SEED_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(UNLOCK_ERRS + 1);

  state_t             r_state, w_state_nxt;
  logic [SEED_W-1:0]  r_seed_cnt, w_seed_cnt_nxt;
  logic [MATCH_W-1:0] r_match_cnt, w_match_cnt_nxt;
  logic [MISS_W-1:0]  r_miss_cnt, w_miss_cnt_nxt;

  logic             w_pred;
  logic [WIDTH-1:0] w_sreg_next;
  logic             w_mismatch;
  logic             w_err_now;
  logic             w_locked_nxt;
  logic [ERR_W-1:0] w_err_cnt_nxt;

  prbs_xnor_lfsr #(
    .WIDTH (WIDTH),
    .TAP_A (TAP_A),
    .TAP_B (TAP_B)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .i_shift_en (din_valid),
    .i_sel_pred (r_state != ST_SEED),
    .i_din      (din),
    .o_pred     (w_pred),
    .o_next     (w_sreg_next)
  );

  assign w_mismatch = din_valid && (din != w_pred);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SEED;
      r_seed_cnt  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_seed_cnt  <= w_seed_cnt_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_miss_cnt  <= w_miss_cnt_nxt;
      locked      <= w_locked_nxt;
      err_pulse   <= w_err_now;
      err_cnt     <= w_err_cnt_nxt;
    end
  end

  // Next state and sequencing counters; the seed window is judged on the register including the last seed bit
  always_comb begin
    w_state_nxt     = r_state;
    w_seed_cnt_nxt  = r_seed_cnt;
    w_match_cnt_nxt = r_match_cnt;
    w_miss_cnt_nxt  = r_miss_cnt;
    if (din_valid) begin
      case (r_state)
        ST_SEED: begin
          if (r_seed_cnt == SEED_W'(WIDTH - 1)) begin
            w_seed_cnt_nxt = '0;
            if (!(&w_sreg_next)) begin
              w_state_nxt     = ST_VERIFY;
              w_match_cnt_nxt = '0;
            end
          end else begin
            w_seed_cnt_nxt = r_seed_cnt + SEED_W'(1);
          end
        end
        ST_VERIFY: begin
          if (w_mismatch) begin
            w_state_nxt    = ST_SEED;
            w_seed_cnt_nxt = '0;
          end else if (r_match_cnt + MATCH_W'(1) == MATCH_W'(LOCK_CNT)) begin
            w_state_nxt    = ST_LOCKED;
            w_miss_cnt_nxt = '0;
          end else begin
            w_match_cnt_nxt = r_match_cnt + MATCH_W'(1);
          end
        end
        ST_LOCKED: begin
          if (w_mismatch) begin
            if (r_miss_cnt + MISS_W'(1) == MISS_W'(UNLOCK_ERRS)) begin
              w_state_nxt    = ST_SEED;
              w_seed_cnt_nxt = '0;
              w_miss_cnt_nxt = '0;
            end else begin
              w_miss_cnt_nxt = r_miss_cnt + MISS_W'(1);
            end
          end else begin
            w_miss_cnt_nxt = '0;
          end
        end
        default: begin
          w_state_nxt    = ST_SEED;
          w_seed_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Output next values; clear wins over accumulation but keeps a coincident error
  always_comb begin
    w_err_now     = (r_state == ST_LOCKED) && w_mismatch;
    w_locked_nxt  = (w_state_nxt == ST_LOCKED);
    w_err_cnt_nxt = err_cnt;
    if (clear_err) begin
      w_err_cnt_nxt = ERR_W'(w_err_now);
    end else if (w_err_now && (err_cnt != {ERR_W{1'b1}})) begin
      w_err_cnt_nxt = err_cnt + ERR_W'(1);
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  logic                w_bit_now;
  logic [BITCNT_W-1:0] w_bit_cnt_nxt;

  always_comb begin
    w_bit_now     = (r_state == ST_LOCKED) && din_valid;
    w_bit_cnt_nxt = bit_cnt;
    if (clear_err) begin
      w_bit_cnt_nxt = BITCNT_W'(w_bit_now);
    end else if (w_bit_now && (bit_cnt != {BITCNT_W{1'b1}})) begin
      w_bit_cnt_nxt = bit_cnt + BITCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= w_bit_cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_prbs_xnor_checker.sv
// Directed bench for prbs_xnor_checker: a default instance and an ERR_W=4 instance share one stimulus.
module tb_prbs_xnor_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, din_valid, din, clear_err;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;
  logic        locked4, err_pulse4;
  logic [3:0]  err_cnt4;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] bit_cnt, bit_cnt4;
`endif

  int total = 0;
  int bad   = 0;
  logic [6:0] g;

  prbs_xnor_checker dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .clear_err (clear_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
`ifdef PRBS_CHK_BITCNT_EN
    ,
    .bit_cnt   (bit_cnt)
`endif
  );

  prbs_xnor_checker #(.ERR_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .clear_err (clear_err),
    .locked    (locked4),
    .err_pulse (err_pulse4),
    .err_cnt   (err_cnt4)
`ifdef PRBS_CHK_BITCNT_EN
    ,
    .bit_cnt   (bit_cnt4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic lk, input logic ep, input int ec, input int ec4);
    chk({tag, ".locked"},     32'(locked),     32'(lk));
    chk({tag, ".err_pulse"},  32'(err_pulse),  32'(ep));
    chk({tag, ".err_cnt"},    32'(err_cnt),    32'(ec));
    chk({tag, ".locked4"},    32'(locked4),    32'(lk));
    chk({tag, ".err_pulse4"}, 32'(err_pulse4), 32'(ep));
    chk({tag, ".err_cnt4"},   32'(err_cnt4),   32'(ec4));
  endtask

  task automatic tick(input logic v, input logic d, input logic c, input logic r);
    rst       = r;
    din_valid = v;
    din       = d;
    clear_err = c;
    @(posedge clk);
    #1;
  endtask

  // Reference XNOR PRBS7 generator, x^7+x^6+1
  task automatic send(input logic inv, input logic c);
    logic b;
    b = ~(g[6] ^ g[5]);
    g = {g[5:0], b};
    tick(1'b1, b ^ inv, c, 1'b0);
  endtask

  initial begin
    int e;
    g = 7'd0;
    rst = 1'b1; din_valid = 1'b0; din = 1'b0; clear_err = 1'b0;

    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk_st("reset", 1'b0, 1'b0, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Lockup pattern: 28 ones keep the checker in SEED with the seed counter back at zero
    for (int i = 0; i < 28; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      chk_st("lockup", 1'b0, 1'b0, 0, 0);
    end

    // Golden stream from seed 0: lock the cycle after the 15th bit
    for (int i = 0; i < 14; i++) begin
      send(1'b0, 1'b0);
      chk_st("acquire", 1'b0, 1'b0, 0, 0);
    end
    send(1'b0, 1'b0);
    chk_st("lock15", 1'b1, 1'b0, 0, 0);
    for (int i = 15; i < 1000; i++) begin
      send(1'b0, 1'b0);
      chk_st("clean", 1'b1, 1'b0, 0, 0);
    end

    // Single inverted bit: one pulse, no propagation
    send(1'b1, 1'b0);
    chk_st("err1", 1'b1, 1'b1, 1, 1);
    for (int i = 0; i < 50; i++) begin
      send(1'b0, 1'b0);
      chk_st("post_err1", 1'b1, 1'b0, 1, 1);
    end

    // Four consecutive errors force resync; the fourth is still counted
    for (int k = 1; k <= 3; k++) begin
      send(1'b1, 1'b0);
      chk_st("burst", 1'b1, 1'b1, 1 + k, 1 + k);
    end
    send(1'b1, 1'b0);
    chk_st("burst4", 1'b0, 1'b1, 5, 5);
    for (int i = 0; i < 14; i++) begin
      send(1'b0, 1'b0);
      chk_st("relock", 1'b0, 1'b0, 5, 5);
    end
    send(1'b0, 1'b0);
    chk_st("relock15", 1'b1, 1'b0, 5, 5);

    // Isolated errors: the 4-bit counter saturates at 15
    for (int k = 1; k <= 20; k++) begin
      e = 5 + k;
      send(1'b1, 1'b0);
      chk_st("sat_err", 1'b1, 1'b1, e, (e > 15) ? 15 : e);
      send(1'b0, 1'b0);
      chk_st("sat_gap", 1'b1, 1'b0, e, (e > 15) ? 15 : e);
    end
    send(1'b1, 1'b1);
    chk_st("clr_with_err", 1'b1, 1'b1, 1, 1);
    send(1'b0, 1'b1);
    chk_st("clr_alone", 1'b1, 1'b0, 0, 0);

    // Valid gaps with garbage data must not disturb the predictor
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, k[0], 1'b0, 1'b0);
      chk_st("gap_idle", 1'b1, 1'b0, (k > 5) ? 1 : 0, (k > 5) ? 1 : 0);
      send(k == 5, 1'b0);
      chk_st("gap_bit", 1'b1, k == 5, (k >= 5) ? 1 : 0, (k >= 5) ? 1 : 0);
    end

    // Reset while locked discards everything on that edge
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    chk_st("rst_mid", 1'b0, 1'b0, 0, 0);
`ifdef PRBS_CHK_BITCNT_EN
    chk("rst_mid.bit_cnt", bit_cnt, 32'd0);
`endif
    for (int i = 0; i < 14; i++) begin
      send(1'b0, 1'b0);
      chk_st("post_rst", 1'b0, 1'b0, 0, 0);
    end
    send(1'b0, 1'b0);
    chk_st("post_rst15", 1'b1, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
